// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave state type and byte-lane helper for the AHB slave memory.
package ahb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_e;

    // Attributes of an accepted address phase carried into its data phase.
    typedef struct packed {
        logic       write;
        logic       legal;
        logic [3:0] be;
    } addr_phase_t;

    // Little-endian byte-lane enables for a transfer of the given size.
    function automatic logic [3:0] byte_enable(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = 4'b0011 << lo;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite slave-port signal bundle; hready is the bus-level ready returned by the interconnect.
interface ahb_slave_mem_if;
    import ahb_pkg::*;

    logic              hsel;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic [1:0]        htrans;
    logic              hmastlock;
    logic              hready;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyout;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hready, hwdata,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_slave_ram.sv
// Word-organised storage with one byte-enabled write port and one asynchronous read port.
module ahb_slave_ram
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned IDX_W     = 8
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: address decode, wait-state FSM, write commit and read forwarding.
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           hclk,
    input  logic           hreset,
    ahb_slave_mem_if.slave bus
);

    localparam int unsigned       IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_WORDS * 4);
    localparam logic [CNT_W-1:0]  WAIT_INIT  = CNT_W'(WAIT_STATES);

    slave_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hreadyout_q, hreadyout_d;
    logic              hresp_q, hresp_d;
    logic [DATA_W-1:0] hrdata_q;
    addr_phase_t       aph_q, aph_c;
    logic [IDX_W-1:0]  widx_q, ridx_c;
    logic              accept_c, take_c, align_c, legal_c, commit_c, launch_c;
    logic [3:0]        ram_we_c;
    logic [DATA_W-1:0] ram_rdata_c, fwd_c;
    logic              unused_ok;

    assign unused_ok = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.htrans[0]};

    // Address-phase decode and legality.
    always_comb begin
        accept_c = bus.hsel & bus.hready & bus.htrans[1];
        take_c   = accept_c & hreadyout_q;
        case (bus.hsize)
            HSIZE_BYTE: align_c = 1'b1;
            HSIZE_HALF: align_c = ~bus.haddr[0];
            HSIZE_WORD: align_c = (bus.haddr[1:0] == 2'b00);
            default:    align_c = 1'b0;
        endcase
        legal_c     = align_c & (bus.haddr < ADDR_LIMIT);
        ridx_c      = bus.haddr[IDX_W+1:2];
        aph_c.write = bus.hwrite;
        aph_c.legal = legal_c;
        aph_c.be    = byte_enable(bus.hsize, bus.haddr[1:0]);
    end

    // Commit in the completing data cycle; a same-word read sees the new bytes.
    always_comb begin
        commit_c = (state_q == ST_DATA) && (cnt_q == '0) && aph_q.write && aph_q.legal;
        ram_we_c = commit_c ? aph_q.be : 4'b0000;
        fwd_c    = ram_rdata_c;
        for (int b = 0; b < 4; b++) begin
            if (ram_we_c[b] && (widx_q == ridx_c)) begin
                fwd_c[8*b +: 8] = bus.hwdata[8*b +: 8];
            end
        end
    end

    // Next state; hreadyout/hresp are decoded from the next state so they leave flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: launch_c = 1'b1;
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    launch_c = 1'b1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        if (launch_c) begin
            if (!accept_c) begin
                state_d = ST_IDLE;
            end else if (legal_c) begin
                state_d = ST_DATA;
                cnt_d   = WAIT_INIT;
            end else begin
                state_d = ST_ERR1;
            end
        end
        hreadyout_d = !((state_d == ST_ERR1) || ((state_d == ST_DATA) && (cnt_d != '0)));
        hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Capture address-phase attributes; load read data on a legal read accept.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            aph_q    <= '0;
            widx_q   <= '0;
            hrdata_q <= '0;
        end else if (take_c) begin
            aph_q  <= aph_c;
            widx_q <= ridx_c;
            if (legal_c && !bus.hwrite) begin
                hrdata_q <= fwd_c;
            end
        end
    end

    ahb_slave_ram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_ram (
        .clk     (hclk),
        .we      (ram_we_c),
        .waddr   (widx_q),
        .wdata   (bus.hwdata),
        .raddr   (ridx_c),
        .rdata_c (ram_rdata_c)
    );

    assign bus.hreadyout = hreadyout_q;
    assign bus.hresp     = hresp_q;
    assign bus.hrdata    = hrdata_q;

endmodule
